// File: rtl/queen_out_monitor_if.sv
// rtl/queen_out_monitor_if.sv - snooped stimulus/solution bus and verdict outputs of the 12-queens monitor
//
// Purpose: bundles everything the monitor observes and reports.
// Signals:
//   in_valid, in_valid_num, col[3:0], row[3:0], in_num[2:0] : snooped preset stimulus
//   out_valid, out[3:0]                                      : snooped solver output, one row per column beat
//   chk_done, chk_pass, chk_err[2:0], chk_col[3:0]           : verdict from the monitor
// Modports: master drives the snooped signals and reads the verdict; slave is the monitor itself.

interface queen_out_monitor_if;
    logic       in_valid;
    logic       in_valid_num;
    logic [3:0] col;
    logic [3:0] row;
    logic [2:0] in_num;
    logic       out_valid;
    logic [3:0] out;
    logic       chk_done;
    logic       chk_pass;
    logic [2:0] chk_err;
    logic [3:0] chk_col;

    modport master (
        output in_valid, in_valid_num, col, row, in_num, out_valid, out,
        input  chk_done, chk_pass, chk_err, chk_col
    );

    modport slave (
        input  in_valid, in_valid_num, col, row, in_num, out_valid, out,
        output chk_done, chk_pass, chk_err, chk_col
    );
endinterface

// File: rtl/queen_out_monitor.sv
// rtl/queen_out_monitor.sv - checks a 12-queens solver's output stream against its preset stimulus
//
// Purpose: captures the preset queens of a pattern, then checks the 12 solution beats for
// out-of-range rows, repeated rows, diagonal attacks and preset violations, and reports a
// one-cycle verdict with the first error code and column.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : queen_out_monitor_if.slave (snooped inputs, chk_* verdict outputs)
// Error codes: 1 row>11, 2 row repeat, 3 diagonal, 4 preset mismatch, 5 short, 6 overrun/abort, 7 bad preset.

module queen_out_monitor (
    input  logic               clk,
    input  logic               rst_n,
    queen_out_monitor_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CAPTURE, WAIT, COLLECT, REPORT} state_t;

    state_t            state_q;
    state_t            state_nx;
    logic [3:0]        k_q;
    logic [3:0]        cnt_q;
    logic [2:0]        num_q;
    logic [11:0]       preset_vld_q;
    logic [11:0][3:0]  preset_row_q;
    logic [11:0]       row_used_q;
    logic [22:0]       diag_a_q;
    logic [22:0]       diag_b_q;
    logic [2:0]        err_q;
    logic [3:0]        ecol_q;
    logic              complete_q;

    logic              cap_beat;
    logic              sol_beat;
    logic              clr;
    logic              go_report;
    logic              overrun;
    logic [2:0]        new_err;
    logic [3:0]        new_col;
    logic [2:0]        fin_err;
    logic [3:0]        fin_col;
    logic              pre_err;
    logic [3:0]        pre_col;
    logic [2:0]        sol_code;

    logic              col_ok;
    logic              row_ok;
    logic              r_ok;
    logic [3:0]        cnt_eff;
    logic [2:0]        num_eff;
    logic [4:0]        da;
    logic [4:0]        db;

    assign col_ok  = (bus.col < 4'd12);
    assign row_ok  = (bus.row < 4'd12);
    assign r_ok    = (bus.out < 4'd12);
    // The first preset beat is taken in IDLE, before in_num and the beat count are latched.
    assign cnt_eff = (state_q == IDLE) ? 4'd0 : cnt_q;
    assign num_eff = (state_q == IDLE) ? bus.in_num : num_q;
    // Anti-diagonal index r+k and diagonal index r-k+11, both 0..22 for legal rows.
    assign da      = {1'b0, bus.out} + {1'b0, k_q};
    assign db      = {1'b0, bus.out} + 5'd11 - {1'b0, k_q};

    always_comb begin
        pre_err = 1'b0;
        pre_col = 4'd0;
        if (!col_ok || !row_ok || (col_ok && preset_vld_q[bus.col])) begin
            pre_err = 1'b1;
            pre_col = bus.col;
        end else if (cnt_eff >= {1'b0, num_eff}) begin
            // more preset beats than announced
            pre_err = 1'b1;
            pre_col = 4'd0;
        end
    end

    always_comb begin
        sol_code = 3'd0;
        if (!r_ok)
            sol_code = 3'd1;
        else if (row_used_q[bus.out])
            sol_code = 3'd2;
        else if (diag_a_q[da] || diag_b_q[db])
            sol_code = 3'd3;
        else if (preset_vld_q[k_q] && (preset_row_q[k_q] != bus.out))
            sol_code = 3'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_nx;
    end

    always_comb begin
        state_nx  = state_q;
        cap_beat  = 1'b0;
        sol_beat  = 1'b0;
        clr       = 1'b0;
        go_report = 1'b0;
        overrun   = 1'b0;
        new_err   = 3'd0;
        new_col   = 4'd0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.in_valid_num) begin
                    cap_beat = 1'b1;
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                if (bus.in_valid) begin
                    cap_beat = 1'b1;
                end else begin
                    if (cnt_q != {1'b0, num_q}) begin
                        new_err = 3'd7;
                        new_col = 4'd0;
                    end
                    state_nx = WAIT;
                end
            end
            WAIT, COLLECT: begin
                if (bus.in_valid) begin
                    // new stimulus while a solution is pending: abort without capturing it
                    new_err   = 3'd6;
                    new_col   = k_q;
                    go_report = 1'b1;
                end else if (bus.out_valid) begin
                    sol_beat = 1'b1;
                    state_nx = COLLECT;
                    if (k_q == 4'd11)
                        go_report = 1'b1;
                end else if (state_q == COLLECT) begin
                    new_err   = 3'd5;
                    new_col   = k_q;
                    go_report = 1'b1;
                end
            end
            REPORT: begin
                clr      = 1'b1;
                state_nx = IDLE;
                overrun  = bus.out_valid && complete_q;
            end
            default: state_nx = IDLE;
        endcase
        if (cap_beat && pre_err) begin
            new_err = 3'd7;
            new_col = pre_col;
        end
        if (sol_beat && (sol_code != 3'd0)) begin
            new_err = sol_code;
            new_col = k_q;
        end
        if (go_report)
            state_nx = REPORT;
    end

    // Only the first error of a pattern is kept; preset errors come first in time, so they win.
    assign fin_err = (err_q != 3'd0) ? err_q  : new_err;
    assign fin_col = (err_q != 3'd0) ? ecol_q : new_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q          <= 4'd0;
            cnt_q        <= 4'd0;
            num_q        <= 3'd0;
            preset_vld_q <= '0;
            preset_row_q <= '0;
            row_used_q   <= '0;
            diag_a_q     <= '0;
            diag_b_q     <= '0;
            err_q        <= 3'd0;
            ecol_q       <= 4'd0;
            complete_q   <= 1'b0;
            bus.chk_done <= 1'b0;
            bus.chk_pass <= 1'b0;
            bus.chk_err  <= 3'd0;
            bus.chk_col  <= 4'd0;
        end else begin
            complete_q <= sol_beat && go_report;
            if (clr) begin
                k_q          <= 4'd0;
                cnt_q        <= 4'd0;
                preset_vld_q <= '0;
                row_used_q   <= '0;
                diag_a_q     <= '0;
                diag_b_q     <= '0;
                err_q        <= 3'd0;
                ecol_q       <= 4'd0;
            end else begin
                if ((err_q == 3'd0) && (new_err != 3'd0)) begin
                    err_q  <= new_err;
                    ecol_q <= new_col;
                end
                if (cap_beat) begin
                    if (state_q == IDLE)
                        num_q <= bus.in_num;
                    cnt_q <= (cnt_eff == 4'd15) ? 4'd15 : cnt_eff + 4'd1;
                    if (col_ok && row_ok) begin
                        preset_row_q[bus.col] <= bus.row;
                        preset_vld_q[bus.col] <= 1'b1;
                    end
                end
                if (sol_beat) begin
                    k_q <= k_q + 4'd1;
                    if (r_ok) begin
                        row_used_q[bus.out] <= 1'b1;
                        diag_a_q[da]        <= 1'b1;
                        diag_b_q[db]        <= 1'b1;
                    end
                end
            end

            if (go_report) begin
                bus.chk_done <= 1'b1;
                bus.chk_pass <= (fin_err == 3'd0);
                bus.chk_err  <= fin_err;
                bus.chk_col  <= (fin_err == 3'd0) ? 4'd0 : fin_col;
            end else if (overrun) begin
                bus.chk_done <= 1'b1;
                bus.chk_pass <= 1'b0;
                bus.chk_err  <= 3'd6;
                bus.chk_col  <= 4'd12;
            end else begin
                bus.chk_done <= 1'b0;
            end
        end
    end
endmodule
